// File: rtl/comms_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comms_pkg
// Purpose  : Shared types and sizing helpers for the serial frame link.
// Revision : 1.0
// ============================================================================
package comms_pkg;

  localparam int FRAME_BITS_DEFAULT = 256;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } link_state_e;

  // Counter width needed to index n items (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : edge_sync
// Purpose  : Multi-flop synchronizer with rising-edge detect on the synced level.
// Revision : 1.0
// ============================================================================
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_rx
// Purpose  : Oversampling receiver assembling LSB-first serial frames into a
//            valid/ack holding register, with timeout and overrun reporting.
// Revision : 1.0
// ============================================================================
module serial_frame_rx
  import comms_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int TIMEOUT_CYC = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clkIn,
  input  logic                          dataIn,
  output logic [FRAME_BITS-1:0]         rxData,
  output logic                          rxValid,
  input  logic                          rxAck,
  output logic                          busy,
  output logic [$clog2(FRAME_BITS)-1:0] bitCount,
  output logic                          frameError,
  output logic                          overrun
);

  localparam int                  c_cnt_w    = cnt_width(FRAME_BITS);
  localparam int                  c_idle_w   = cnt_width(TIMEOUT_CYC);
  localparam logic [c_cnt_w-1:0]  c_last_bit = c_cnt_w'(FRAME_BITS - 1);
  localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(TIMEOUT_CYC - 1);

  logic w_sclk_rise;
  logic w_sclk_level_unused;
  logic w_sdata;
  logic w_sdata_rise_unused;
  logic w_complete;

  link_state_e             state_q,     state_d;
  logic [c_cnt_w-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [c_idle_w-1:0]     idle_cnt_q,  idle_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q,     shift_d;
  logic [FRAME_BITS-1:0]   rx_data_q,   rx_data_d;
  logic                    rx_valid_q,  rx_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overrun_q,   overrun_d;

  // Equal synchronizer depth keeps data aligned with the serial clock edge.
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk     (clk),
    .rst     (rst),
    .d_i     (clkIn),
    .level_o (w_sclk_level_unused),
    .rise_o  (w_sclk_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk     (clk),
    .rst     (rst),
    .d_i     (dataIn),
    .level_o (w_sdata),
    .rise_o  (w_sdata_rise_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    w_complete  = 1'b0;

    if (w_sclk_rise) begin
      shift_d[bit_cnt_q] = w_sdata;
      bit_cnt_d          = bit_cnt_q + c_cnt_w'(1);
      idle_cnt_d         = '0;
      state_d            = ST_RECV;
      if (bit_cnt_q == c_last_bit) begin
        w_complete = 1'b1;
        bit_cnt_d  = '0;
        state_d    = ST_IDLE;
      end
    end else if (state_q == ST_RECV) begin
      if (idle_cnt_q == c_idle_max) begin
        frame_err_d = 1'b1;
        bit_cnt_d   = '0;
        idle_cnt_d  = '0;
        shift_d     = '0;
        state_d     = ST_IDLE;
      end else begin
        idle_cnt_d = idle_cnt_q + c_idle_w'(1);
      end
    end

    // A same-cycle ack frees the holding register for the new frame.
    if (w_complete) begin
      if (!rx_valid_q || rxAck) begin
        rx_data_d  = shift_d;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rxAck && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rxData     = rx_data_q;
  assign rxValid    = rx_valid_q;
  assign busy       = (state_q == ST_RECV);
  assign bitCount   = bit_cnt_q;
  assign frameError = frame_err_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_rx
// Purpose  : Directed self-checking bench for serial_frame_rx.
// Revision : 1.0
// ============================================================================
module tb_serial_frame_rx;

  localparam int FB = 256;

  localparam logic [FB-1:0] FR_A = (256'd1 << 255) | 256'd1;
  localparam logic [FB-1:0] FR_B =
    256'h3030303003030303303030300000000000000000010101011010101001010101;
  localparam logic [FB-1:0] FR_C = {4{64'hA5A5_0F0F_C3C3_1234}};
  localparam logic [FB-1:0] FR_D = {8{32'hDEAD_BEEF}};
  localparam logic [FB-1:0] FR_E = {8{32'h1234_5678}};
  localparam logic [FB-1:0] FR_F = {8{32'h0BAD_F00D}};
  localparam logic [FB-1:0] FR_G = {8{32'hCAFE_F00D}};
  localparam logic [FB-1:0] FR_H = ~FR_B;

  logic          clk = 1'b0;
  logic          rst;
  logic          clkIn;
  logic          dataIn;
  logic          rxAck;
  logic [FB-1:0] rxData;
  logic          rxValid;
  logic          busy;
  logic [7:0]    bitCount;
  logic          frameError;
  logic          overrun;

  int   errors        = 0;
  int   checks        = 0;
  int   cyc           = 0;
  int   valid_rises   = 0;
  int   fe_count      = 0;
  int   fe_cyc        = -1;
  int   last_rise_cyc = 0;
  int   vr0           = 0;
  logic prev_valid    = 1'b0;

  serial_frame_rx #(
    .FRAME_BITS  (FB),
    .TIMEOUT_CYC (64),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clkIn      (clkIn),
    .dataIn     (dataIn),
    .rxData     (rxData),
    .rxValid    (rxValid),
    .rxAck      (rxAck),
    .busy       (busy),
    .bitCount   (bitCount),
    .frameError (frameError),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxValid === 1'b1 && prev_valid !== 1'b1) valid_rises++;
    prev_valid = rxValid;
    if (frameError === 1'b1) begin
      fe_count++;
      fe_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One serial bit: clkIn high 4 cycles, low 4 cycles; optional ack on the
  // clk edge that captures this bit (third posedge after the rise).
  task automatic send_bit(input logic b, input logic ack_on_capture);
    dataIn        = b;
    clkIn         = 1'b1;
    last_rise_cyc = cyc;
    tick(2);
    if (ack_on_capture) rxAck = 1'b1;
    tick(1);
    rxAck = 1'b0;
    tick(1);
    clkIn = 1'b0;
    tick(4);
  endtask

  task automatic send_frame(input logic [FB-1:0] f, input int nbits, input logic ack_last);
    for (int i = 0; i < nbits; i++) send_bit(f[i], ack_last && (i == nbits - 1));
  endtask

  task automatic pulse_ack();
    rxAck = 1'b1;
    tick(1);
    rxAck = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rxData"},     rxData,          '0);
    chk({tag, "_rxValid"},    FB'(rxValid),    '0);
    chk({tag, "_busy"},       FB'(busy),       '0);
    chk({tag, "_bitCount"},   FB'(bitCount),   '0);
    chk({tag, "_frameError"}, FB'(frameError), '0);
    chk({tag, "_overrun"},    FB'(overrun),    '0);
  endtask

  initial begin
    rst    = 1'b1;
    clkIn  = 1'b0;
    dataIn = 1'b0;
    rxAck  = 1'b0;
    @(negedge clk);
    tick(2);
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Single frame with only the end bits set
    send_frame(FR_A, FB, 1'b0);
    tick(2);
    chk("t1_valid_rises", FB'(valid_rises), FB'(1));
    chk("t1_rxData",      rxData,           FR_A);
    chk("t1_rxValid",     FB'(rxValid),     FB'(1));
    chk("t1_bitCount",    FB'(bitCount),    '0);
    chk("t1_busy",        FB'(busy),        '0);
    chk("t1_fe_count",    FB'(fe_count),    '0);

    // Ack, then mixed-pattern frame and ack latency
    pulse_ack();
    chk("t2_ackA_rxValid", FB'(rxValid), '0);
    send_frame(FR_B, FB, 1'b0);
    tick(2);
    chk("t2_rxData",  rxData,       FR_B);
    chk("t2_rxValid", FB'(rxValid), FB'(1));
    pulse_ack();
    chk("t2_ack_rxValid", FB'(rxValid), '0);
    chk("t2_hold_rxData", rxData,       FR_B);

    // Truncated frame and timeout
    send_frame(FR_C, 100, 1'b0);
    chk("t3_partial_bitCount", FB'(bitCount), FB'(100));
    chk("t3_partial_busy",     FB'(busy),     FB'(1));
    tick(70);
    chk("t3_fe_count",   FB'(fe_count),                FB'(1));
    chk("t3_fe_latency", FB'(fe_cyc - last_rise_cyc),  FB'(67));
    chk("t3_rxValid",    FB'(rxValid),                 '0);
    chk("t3_busy",       FB'(busy),                    '0);
    chk("t3_bitCount",   FB'(bitCount),                '0);
    send_frame(FR_C, FB, 1'b0);
    tick(2);
    chk("t3_next_rxData",  rxData,        FR_C);
    chk("t3_next_rxValid", FB'(rxValid),  FB'(1));
    chk("t3_next_fe",      FB'(fe_count), FB'(1));

    // Back-to-back without ack: overrun
    pulse_ack();
    send_frame(FR_D, FB, 1'b0);
    tick(2);
    chk("t4_first_overrun", FB'(overrun), '0);
    chk("t4_first_rxData",  rxData,       FR_D);
    send_frame(FR_E, FB, 1'b0);
    tick(2);
    chk("t4_rxData",  rxData,       FR_D);
    chk("t4_rxValid", FB'(rxValid), FB'(1));
    chk("t4_overrun", FB'(overrun), FB'(1));

    // Ack coinciding with completion
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    vr0 = valid_rises;
    send_frame(FR_F, FB, 1'b0);
    tick(2);
    chk("t5_first_rxData", rxData, FR_F);
    send_frame(FR_G, FB, 1'b1);
    tick(2);
    chk("t5_rxData",       rxData,           FR_G);
    chk("t5_rxValid",      FB'(rxValid),     FB'(1));
    chk("t5_overrun",      FB'(overrun),     '0);
    chk("t5_valid_rises",  FB'(valid_rises), FB'(vr0 + 1));

    // Reset in the middle of a frame
    send_frame(FR_H, 120, 1'b0);
    rst = 1'b1;
    tick(1);
    chk_reset_outputs("t6_in_reset");
    tick(1);
    rst = 1'b0;
    tick(2);
    send_frame(FR_H, FB, 1'b0);
    tick(2);
    chk("t6_rxData",   rxData,        FR_H);
    chk("t6_rxValid",  FB'(rxValid),  FB'(1));
    chk("t6_bitCount", FB'(bitCount), '0);
    chk("t6_fe_count", FB'(fe_count), FB'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_frame_rx.md
# serial_frame_rx

Synchronous receive endpoint for the two-wire serial frame link (serial clock plus serial data). The link transmitter sends a 256-bit buffer LSB-first, one bit per serial-clock rising edge. This block oversamples both wires in the local `clk` domain and assembles the bits into a frame. It hands each completed frame to the host through a valid/ack holding register, and it flags truncated frames and overruns. It replaces free-running counters clocked directly by `clkIn` with a single-clock, reset-safe design.

## Interface
- `FRAME_BITS`, 256, bits per frame; must be a power of two, ≥ 8.
- `TIMEOUT_CYC`, 64, `clk` cycles with no serial edge after which a partial frame is abandoned.
- `SYNC_STAGES`, 2, flip-flop depth of the input synchronizers; must be ≥ 2.
- `clk`  in  1  local clock.
- `rst`  in  1  asynchronous reset, active-high.
- `clkIn`  in  1  serial clock from the link, asynchronous to `clk`.
- `dataIn`  in  1  serial data from the link, valid around the `clkIn` rising edge.
- `rxData`  out  FRAME_BITS  last accepted frame; bit i is the i-th received bit.
- `rxValid`  out  1  `rxData` holds an unacknowledged frame.
- `rxAck`  in  1  host consumes the frame; only meaningful while `rxValid` = 1.
- `busy`  out  1  a frame is partially received (state RECV).
- `bitCount`  out  $clog2(FRAME_BITS)  bits received so far in the current frame.
- `frameError`  out  1  one-cycle pulse when a partial frame times out.
- `overrun`  out  1  sticky flag: a completed frame was dropped because `rxValid` was still held.

## Operation
- Input path: `clkIn` and `dataIn` each pass through `SYNC_STAGES` flip-flops, with equal depth so the two stay aligned.
- Rising-edge detect: `sclkRise` = synchronized `clkIn` AND NOT its previous value.
- On `sclkRise`, the synchronized data is written to `shiftReg[bitCount]` and `bitCount` increments, wrapping at FRAME_BITS.
- States:
  - IDLE: `bitCount` = 0. The first `sclkRise` captures bit 0 and moves to RECV.
  - RECV: captures bits on each `sclkRise`. The capture of bit FRAME_BITS-1 completes the frame: `bitCount` wraps to 0 and the state returns to IDLE.
- Timeout: `idleCnt` counts `clk` cycles in RECV and is cleared on every `sclkRise`. When `idleCnt` = TIMEOUT_CYC-1:
  - `frameError` pulses for one cycle.
  - `bitCount` is cleared and the state moves to IDLE.
  - `shiftReg` contents are discarded and `rxData` is untouched.
- Frame completion:
  - If `rxValid` = 0, or `rxAck` = 1 in the same cycle: `rxData` ← `shiftReg` (including the bit just captured) and `rxValid` = 1.
  - Otherwise the new frame is dropped, `overrun` is set, and `rxData` and `rxValid` are unchanged.
- `rxAck` while `rxValid` = 1 and no completion occurs that cycle: `rxValid` goes to 0.
- `rxAck` while `rxValid` = 0 is ignored.
- `overrun` clears only on `rst`.
- Reception continues into `shiftReg` while `rxValid` is high, so back-to-back frames are supported as long as the host acknowledges before the next frame completes.
- Line constraint: `clkIn` must stay high and stay low for at least SYNC_STAGES+1 `clk` cycles each. `dataIn` must be stable from the `clkIn` rising edge through SYNC_STAGES+1 cycles. Edges faster than this have undefined results.

## Timing
- Reset values:
  - `rxData` = 0, `rxValid` = 0, `busy` = 0, `bitCount` = 0, `frameError` = 0, `overrun` = 0.
  - Synchronizer flip-flops = 0, state = IDLE, `idleCnt` = 0.
- Capture latency: a `clkIn` rise at the pin is captured SYNC_STAGES+1 `clk` edges later. `bitCount` updates on that same edge.
- `rxValid` rises on the same edge that captures the last bit, so frame latency equals capture latency.
- `rxData` is constant while `rxValid` = 1, except when a same-cycle ack and completion load a new frame.
- A pulse on `rst` in the middle of a frame aborts it with no `frameError`. Reception resumes with the next edge counted as bit 0. The host must re-align at the frame level.
- `busy` = (state == RECV). It falls on the completion edge or the timeout edge.

## Structure
- Shared package `comms_pkg`: FRAME_BITS default, the state enum (IDLE, RECV), and the bit-counter width function. The transmitter uses the same package.
- Sub-module `edge_sync` (parameter SYNC_STAGES): synchronizes one wire and outputs both the synced level and the rising-edge pulse. It is instantiated for `clkIn`; `dataIn` uses the level-only output of a second instance.
- Everything else lives in `serial_frame_rx`: FSM, counters, `shiftReg`, holding register.

## Test plan
- Send frame `(1<<255) | 1` with serial clock = `clk`/8 → exactly one `rxValid`; `rxData` = 256'h8000…0001; `bitCount` returns to 0; `frameError` = 0.
- Send 256'h3030303003030303303030300000000000000000010101011010101001010101, then assert `rxAck` → `rxData` matches bit-for-bit; `rxValid` drops one cycle after the ack.
- Send 100 bits, then hold `clkIn` low for 70 cycles → `frameError` pulses once at cycle 64; `rxValid` stays 0; the next full frame is received correctly.
- Send two frames back-to-back with no ack → the first frame remains in `rxData`; `overrun` = 1 after the second completion; `rxValid` stays 1.
- Assert `rxAck` on the exact cycle the second frame completes → `rxData` = second frame; `rxValid` stays 1; `overrun` = 0.
- Pulse `rst` at bit 120, then send a full frame → all outputs are at reset values during reset; the frame is received intact; no `frameError`.
